// File: rtl/cp_timing_detect_pkg.sv
// Shared types and constants for CP-based symbol timing detection.
// Includes the wrapped index distance used by the lock tracker.
package cp_timing_detect_pkg;

  localparam int N_FFT      = 64;
  localparam int L_CP       = 16;
  localparam int SYM_LEN    = N_FFT + L_CP;
  localparam int PHI_W      = 14;
  localparam int THETA_TOL  = 1;
  localparam int LOCK_MATCH = 3;
  localparam int IDX_W      = $clog2(SYM_LEN);
  localparam int CNT_W      = $clog2(LOCK_MATCH + 1);

  typedef logic signed [PHI_W-1:0] phi_t;
  typedef logic signed [PHI_W:0]   metric_t;
  typedef logic [IDX_W-1:0]        idx_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FIRST = 2'd1,
    S_TRACK = 2'd2
  } state_t;

  // Distance between two window indices on a ring of length len.
  function automatic idx_t circ_dist(input idx_t a, input idx_t b, input int len);
    int d;
    d = (a > b) ? (int'(a) - int'(b)) : (int'(b) - int'(a));
    if (d > len / 2) d = len - d;
    return idx_t'(d);
  endfunction

endpackage

// File: rtl/cp_lock_tracker.sv
// Tracks theta stability across windows and raises locked after
// LOCK_MATCH consecutive matching windows.
module cp_lock_tracker
  import cp_timing_detect_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic sync_clr,
  input  logic theta_strobe,
  input  logic track_en,
  input  idx_t theta_new,
  output logic locked
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_MATCH);
  localparam idx_t             TOL     = idx_t'(THETA_TOL);

  idx_t             prev_theta;
  logic [CNT_W-1:0] lock_cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic             match;

  assign match   = (circ_dist(theta_new, prev_theta, SYM_LEN) <= TOL);
  assign cnt_inc = (lock_cnt == CNT_MAX) ? CNT_MAX : lock_cnt + 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_theta <= '0;
      lock_cnt   <= '0;
      locked     <= 1'b0;
    end else if (sync_clr) begin
      prev_theta <= '0;
      lock_cnt   <= '0;
      locked     <= 1'b0;
    end else if (theta_strobe) begin
      prev_theta <= theta_new;
      // The first window only seeds prev_theta; there is nothing to compare yet.
      if (track_en && match) begin
        lock_cnt <= cnt_inc;
        locked   <= (cnt_inc == CNT_MAX);
      end else begin
        lock_cnt <= '0;
        locked   <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/cp_timing_detect.sv
// ML symbol-timing search: forms |gamma| - phi, finds the per-window argmax
// and hands each winner to the lock tracker.
module cp_timing_detect
  import cp_timing_detect_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             sync_clr,
  input  logic             valid_in,
  input  logic [PHI_W-1:0] gamma_mag_in,
  input  logic [PHI_W-1:0] phi_in,
  output logic             theta_valid,
  output logic [IDX_W-1:0] theta_out,
  output logic [PHI_W:0]   metric_max,
  output logic             locked
);

  // state   | meaning
  // S_IDLE  | waiting for the first valid sample after reset or sync_clr
  // S_FIRST | searching the first window; its theta only seeds the tracker
  // S_TRACK | searching later windows; each theta is compared for lock

  localparam idx_t IDX_LAST = idx_t'(SYM_LEN - 1);

  state_t  state_q, state_d;
  idx_t    idx;
  idx_t    run_idx, win_idx;
  metric_t run_max, win_max;
  metric_t g_ext, p_ext, metric;
  logic    accept, last, track_en;

  assign g_ext  = {gamma_mag_in[PHI_W-1], gamma_mag_in};
  assign p_ext  = {phi_in[PHI_W-1], phi_in};
  assign metric = g_ext - p_ext;

  assign accept = valid_in && !sync_clr;
  assign last   = accept && (idx == IDX_LAST);

  // Strict compare keeps the earliest index on ties.
  always_comb begin
    win_max = run_max;
    win_idx = run_idx;
    if ((idx == '0) || (metric > run_max)) begin
      win_max = metric;
      win_idx = idx;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx         <= '0;
      run_max     <= '0;
      run_idx     <= '0;
      theta_valid <= 1'b0;
      theta_out   <= '0;
      metric_max  <= '0;
    end else begin
      theta_valid <= last;
      if (sync_clr) begin
        idx     <= '0;
        run_max <= '0;
        run_idx <= '0;
      end else if (valid_in) begin
        idx     <= last ? '0 : idx + 1'b1;
        run_max <= win_max;
        run_idx <= win_idx;
      end
      if (last) begin
        theta_out  <= win_idx;
        metric_max <= win_max;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (sync_clr) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (valid_in) state_d = S_FIRST;
        S_FIRST: if (last)     state_d = S_TRACK;
        S_TRACK: state_d = S_TRACK;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    track_en = (state_q == S_TRACK);
  end

  cp_lock_tracker u_lock (
    .clk          (clk),
    .rst          (rst),
    .sync_clr     (sync_clr),
    .theta_strobe (last),
    .track_en     (track_en),
    .theta_new    (win_idx),
    .locked       (locked)
  );

endmodule

// File: tb/tb_cp_timing_detect.sv
// Bench for cp_timing_detect: table of windows with expected results kept
// in a scoreboard queue, plus reset and sync_clr sequences.
module tb_cp_timing_detect;
  import cp_timing_detect_pkg::*;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             sync_clr = 1'b0;
  logic             valid_in = 1'b0;
  logic [PHI_W-1:0] gamma_mag_in = '0;
  logic [PHI_W-1:0] phi_in = '0;
  logic             theta_valid;
  logic [IDX_W-1:0] theta_out;
  logic [PHI_W:0]   metric_max;
  logic             locked;

  cp_timing_detect dut (
    .clk          (clk),
    .rst          (rst),
    .sync_clr     (sync_clr),
    .valid_in     (valid_in),
    .gamma_mag_in (gamma_mag_in),
    .phi_in       (phi_in),
    .theta_valid  (theta_valid),
    .theta_out    (theta_out),
    .metric_max   (metric_max),
    .locked       (locked)
  );

  always #5 clk = ~clk;

  typedef struct {
    int gb, pb;
    int pka, ga, pa;
    int pkb, gbv;
    bit gaps;
    int th, m;
    bit l;
  } vec_t;

  typedef struct {
    int theta;
    int metric;
    bit lk;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  function automatic vec_t mk(input int gb, pb, pka, ga, pa, pkb, gbv,
                              input bit gaps, input int th, m, input bit l);
    vec_t v;
    v.gb = gb; v.pb = pb; v.pka = pka; v.ga = ga; v.pa = pa;
    v.pkb = pkb; v.gbv = gbv; v.gaps = gaps; v.th = th; v.m = m; v.l = l;
    return v;
  endfunction

  function automatic vec_t pk(input int at, input bit l);
    return mk(0, 0, at, 256, 0, -1, 0, 1'b0, at, 256, l);
  endfunction

  task automatic send(input int g, input int p, input bit v);
    gamma_mag_in = phi_t'(g);
    phi_in       = phi_t'(p);
    valid_in     = v;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_window(input vec_t v);
    int g, p;
    exp_t e;
    for (int i = 0; i < SYM_LEN; i++) begin
      g = v.gb;
      p = v.pb;
      if (i == v.pka) begin g = v.ga; p = v.pa; end
      if (i == v.pkb) g = v.gbv;
      if (i == SYM_LEN - 1) begin
        e.theta = v.th; e.metric = v.m; e.lk = v.l;
        sb.push_back(e);
      end
      send(g, p, 1'b1);
      if (v.gaps) send(8191, 0, 1'b0);
    end
    valid_in = 1'b0;
  endtask

  // Scoreboard consumer: every theta_valid pulse must match a queued window.
  always @(negedge clk) begin
    exp_t e;
    if (theta_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_theta_valid", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("theta_out", int'(theta_out), e.theta);
        chk("metric_max", int'($signed(metric_max)), e.metric);
        chk("locked", int'(locked), int'(e.lk));
      end
    end
  end

  vec_t tbl[18];

  initial begin
    tbl[0]  = pk(37, 0);
    tbl[1]  = pk(37, 0);
    tbl[2]  = mk(0, 5, -1, 0, 0, -1, 0, 1'b0, 0, -5, 0);
    tbl[3]  = mk(0, 0, 10, 128, 0, 50, 128, 1'b0, 10, 128, 0);
    tbl[4]  = mk(0, 0, 20, 256, 0, -1, 0, 1'b1, 20, 256, 0);
    tbl[5]  = pk(37, 0);
    tbl[6]  = pk(38, 0);
    tbl[7]  = pk(37, 0);
    tbl[8]  = pk(37, 1);
    tbl[9]  = pk(37, 1);
    tbl[10] = pk(60, 0);
    tbl[11] = pk(79, 0);
    tbl[12] = pk(0, 0);
    tbl[13] = pk(79, 0);
    tbl[14] = pk(0, 1);
    tbl[15] = mk(0, 256, 5, 8191, -8192, -1, 0, 1'b0, 5, 16383, 0);
    tbl[16] = mk(-8192, 8191, -1, 0, 0, -1, 0, 1'b0, 0, -16383, 0);
    tbl[17] = pk(45, 0);

    repeat (3) @(posedge clk);
    #1;
    chk("rst_theta_valid", int'(theta_valid), 0);
    chk("rst_theta_out", int'(theta_out), 0);
    chk("rst_metric_max", int'(metric_max), 0);
    chk("rst_locked", int'(locked), 0);
    rst = 1'b1;
    send(0, 0, 1'b0);

    foreach (tbl[i]) drive_window(tbl[i]);
    repeat (2) send(0, 0, 1'b0);

    // Reset in the middle of a window discards the partial search.
    for (int i = 0; i <= 40; i++) send(0, 0, 1'b1);
    rst = 1'b0;
    #2;
    chk("mid_rst_theta_valid", int'(theta_valid), 0);
    chk("mid_rst_theta_out", int'(theta_out), 0);
    chk("mid_rst_metric_max", int'(metric_max), 0);
    chk("mid_rst_locked", int'(locked), 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (3) send(0, 0, 1'b0);
    drive_window(pk(37, 0));
    drive_window(pk(37, 0));
    drive_window(pk(37, 0));
    drive_window(pk(37, 1));
    send(0, 0, 1'b0);
    chk("pre_clr_locked", int'(locked), 1);

    // sync_clr mid-window while locked, with valid_in high in the same cycle.
    for (int i = 0; i < 30; i++) send(0, 0, 1'b1);
    sync_clr = 1'b1;
    send(0, 0, 1'b1);
    sync_clr = 1'b0;
    chk("clr_locked", int'(locked), 0);
    chk("clr_theta_out", int'(theta_out), 37);
    chk("clr_theta_valid", int'(theta_valid), 0);
    drive_window(pk(12, 0));
    repeat (5) send(0, 0, 1'b0);
    chk("scoreboard_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
